// File: rtl/banked_memory_pkg.sv
// -----------------------------------------------------------------------------
// banked_memory_pkg
//   Shared definitions for the banked byte-lane memory and for the CPU32
//   load/store decode that drives it.
//   - W_BYTE / W_HALF / W_WORD : access-width codes carried on req_width.
//   - mem_state_t              : controller state (CLEAR after reset, then READY).
//   - rsp_meta_t               : per-request information that travels with a
//                                request through the read-latency pipeline.
// -----------------------------------------------------------------------------
package banked_memory_pkg;

  // Access width in bytes, as presented on req_width.
  localparam logic [3:0] W_BYTE = 4'd1;
  localparam logic [3:0] W_HALF = 4'd2;
  localparam logic [3:0] W_WORD = 4'd4;

  // Number of 8-bit lanes making up one memory word.
  localparam int NUM_LANES = 4;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } mem_state_t;

  // Everything needed to build the response once the lane data arrives.
  typedef struct packed {
    logic       valid;
    logic       fault;
    logic       write;
    logic [3:0] width;
    logic       sign;
    logic [1:0] offset;
  } rsp_meta_t;

endpackage

// File: rtl/banked_memory_mem_lane.sv
// -----------------------------------------------------------------------------
// mem_lane
//   One 8-bit lane of the banked memory: a single-port RAM, DEPTH words deep,
//   with a synchronous write and a registered read (read-before-write when the
//   same word is read and written in one cycle).
//
//   Ports
//     clock    in   system clock
//     wr_en    in   write enable for this lane
//     addr     in   word index (shared by read and write)
//     wr_data  in   byte to store
//     rd_data  out  byte read, valid one cycle after addr is presented
// -----------------------------------------------------------------------------
module mem_lane
  import banked_memory_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                     clock,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [7:0]               wr_data,
  output logic [7:0]               rd_data
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rd_data_q;

  // No reset on the array or the read register: the array is cleared by the
  // controller after reset, and the read data is qualified by pipeline valid.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[addr] <= wr_data;
    end
    rd_data_q <= mem_q[addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/banked_memory.sv
// -----------------------------------------------------------------------------
// banked_memory
//   Byte-addressed, little-endian memory built from four 8-bit lanes, used as
//   CPU32 program and data memory. After reset the whole array is cleared
//   (one word per cycle, MEM_SIZE/4 cycles) before requests are accepted.
//   Requests are fully pipelined: one accept per cycle, each answered by a
//   single-cycle rsp_valid pulse exactly READ_LATENCY cycles later, in order.
//   Stores commit at the accept edge and are acknowledged with rsp_data = 0.
//   Misaligned, illegal-width and out-of-range requests are not performed and
//   answer with rsp_fault = 1, rsp_data = 0.
//
//   Parameters
//     MEM_SIZE      size in bytes, power of two, >= 16
//     READ_LATENCY  accept-to-response cycles, 1..4
//
//   Ports
//     clock        in   system clock, all state on the rising edge
//     reset        in   synchronous, active-high
//     req_valid    in   request present
//     req_ready    out  request can be accepted this cycle
//     req_write    in   1 = store, 0 = load
//     req_width    in   access width in bytes (1, 2 or 4)
//     req_signed   in   sign-extend sub-word loads
//     req_address  in   byte address
//     req_data     in   store data, right-aligned
//     rsp_valid    out  one-cycle response pulse per accepted request
//     rsp_data     out  load result, right-aligned and extended
//     rsp_fault    out  request was not performed
// -----------------------------------------------------------------------------
module banked_memory
  import banked_memory_pkg::*;
#(
  parameter int MEM_SIZE     = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [3:0]  req_width,
  input  logic        req_signed,
  input  logic [31:0] req_address,
  input  logic [31:0] req_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_fault
);

  localparam int ADDR_BITS = $clog2(MEM_SIZE);
  localparam int WORD_BITS = ADDR_BITS - 2;
  localparam int WORDS     = MEM_SIZE / 4;
  localparam logic [WORD_BITS-1:0] LAST_WORD = WORD_BITS'(WORDS - 1);

  // ---------------------------------------------------------------------------
  // Controller: CLEAR walks every word once, then READY forever.
  // ---------------------------------------------------------------------------
  mem_state_t           state_q, state_d;
  logic [WORD_BITS-1:0] clear_cnt_q, clear_cnt_d;
  logic                 clearing;

  always_comb begin
    state_d     = state_q;
    clear_cnt_d = clear_cnt_q;
    req_ready   = 1'b0;
    clearing    = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clearing    = 1'b1;
        clear_cnt_d = clear_cnt_q + 1'b1;
        if (clear_cnt_q == LAST_WORD) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        req_ready = 1'b1;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_CLEAR;
      clear_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      clear_cnt_q <= clear_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Request decode: fault detection and lane selection.
  // ---------------------------------------------------------------------------
  logic                 accept;
  logic                 out_of_range;
  logic                 req_fault;
  logic [3:0]           lane_mask;
  logic [1:0]           req_offset;
  logic [WORD_BITS-1:0] req_word;
  logic                 do_write;

  assign accept     = req_valid & req_ready;
  assign req_offset = req_address[1:0];
  assign req_word   = req_address[ADDR_BITS-1:2];
  // Compare the full address so upper bits never alias onto low memory.
  assign out_of_range = (req_address >= 32'(MEM_SIZE));

  always_comb begin
    req_fault = 1'b1;
    lane_mask = 4'b0000;
    case (req_width)
      W_BYTE: begin
        req_fault = 1'b0;
        lane_mask = 4'b0001 << req_offset;
      end
      W_HALF: begin
        req_fault = req_offset[0];
        lane_mask = req_offset[1] ? 4'b1100 : 4'b0011;
      end
      W_WORD: begin
        req_fault = |req_offset;
        lane_mask = 4'b1111;
      end
      default: begin
        req_fault = 1'b1;
        lane_mask = 4'b0000;
      end
    endcase
    if (out_of_range) begin
      req_fault = 1'b1;
    end
  end

  assign do_write = accept & req_write & ~req_fault;

  // ---------------------------------------------------------------------------
  // Lanes. During CLEAR every lane writes zero at the clear counter; otherwise
  // all lanes share the request word index and only selected lanes write.
  // ---------------------------------------------------------------------------
  logic [WORD_BITS-1:0] lane_addr;
  logic [3:0]           lane_we;
  logic [31:0]          lane_wdata;
  logic [31:0]          lane_rdata;

  assign lane_addr = clearing ? clear_cnt_q : req_word;

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    logic [7:0] store_byte;

    // Right-aligned store data is replicated so each lane picks the byte it
    // would hold: a halfword feeds lanes {1,0} and {3,2} alike, a byte feeds all.
    assign store_byte = (req_width == W_WORD) ? req_data[8*gi +: 8] :
                        (req_width == W_HALF) ? req_data[8*(gi%2) +: 8] :
                                                req_data[7:0];

    assign lane_we[gi]            = clearing | (do_write & lane_mask[gi]);
    assign lane_wdata[8*gi +: 8]  = clearing ? 8'h00 : store_byte;

    mem_lane #(
      .DEPTH (WORDS)
    ) u_lane (
      .clock   (clock),
      .wr_en   (lane_we[gi]),
      .addr    (lane_addr),
      .wr_data (lane_wdata[8*gi +: 8]),
      .rd_data (lane_rdata[8*gi +: 8])
    );
  end

  // ---------------------------------------------------------------------------
  // Latency pipeline. Request metadata is shifted READ_LATENCY stages; the lane
  // read data is already one stage late (registered read), so it is delayed a
  // further READ_LATENCY-1 stages to line up with the metadata.
  // ---------------------------------------------------------------------------
  rsp_meta_t meta_q [READ_LATENCY];
  rsp_meta_t meta_d [READ_LATENCY];

  always_comb begin
    meta_d[0].valid  = accept;
    meta_d[0].fault  = req_fault;
    meta_d[0].write  = req_write;
    meta_d[0].width  = req_width;
    meta_d[0].sign   = req_signed;
    meta_d[0].offset = req_offset;
    for (int i = 1; i < READ_LATENCY; i++) begin
      meta_d[i] = meta_q[i-1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        meta_q[i] <= '0;
      end
    end else begin
      meta_q <= meta_d;
    end
  end

  logic [31:0] raw_out;

  if (READ_LATENCY == 1) begin : g_no_delay
    assign raw_out = lane_rdata;
  end else begin : g_delay
    logic [31:0] raw_q [READ_LATENCY-1];
    logic [31:0] raw_d [READ_LATENCY-1];

    always_comb begin
      raw_d[0] = lane_rdata;
      for (int i = 1; i < READ_LATENCY - 1; i++) begin
        raw_d[i] = raw_q[i-1];
      end
    end

    // Data only; qualified by the metadata valid bit, so no reset needed.
    always_ff @(posedge clock) begin
      raw_q <= raw_d;
    end

    assign raw_out = raw_q[READ_LATENCY-2];
  end

  // ---------------------------------------------------------------------------
  // Response formatting: extract the addressed lanes, shift to bit 0, extend.
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [3:0]  width,
                                              input logic        sign,
                                              input logic [1:0]  offset);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    shifted = word >> {offset, 3'b000};
    b       = shifted[7:0];
    h       = offset[1] ? word[31:16] : word[15:0];
    case (width)
      W_BYTE:  return {{24{sign & b[7]}}, b};
      W_HALF:  return {{16{sign & h[15]}}, h};
      default: return word;
    endcase
  endfunction

  rsp_meta_t meta_out;
  assign meta_out = meta_q[READ_LATENCY-1];

  always_comb begin
    rsp_valid = meta_out.valid;
    rsp_fault = meta_out.valid & meta_out.fault;
    rsp_data  = '0;
    if (meta_out.valid && !meta_out.fault && !meta_out.write) begin
      rsp_data = extend_load(raw_out, meta_out.width, meta_out.sign, meta_out.offset);
    end
  end

endmodule

// File: tb/tb_banked_memory.sv
// -----------------------------------------------------------------------------
// tb_banked_memory
//   Drives banked_memory (MEM_SIZE=1024, READ_LATENCY=3) one request per cycle
//   from the falling edge and compares every response against a byte-array
//   reference model and, for the directed cases, against fixed expected values.
// -----------------------------------------------------------------------------
module tb_banked_memory;

  localparam int MEM_SIZE     = 1024;
  localparam int LAT          = 3;
  localparam int CLEAR_CYCLES = MEM_SIZE / 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [3:0]  req_width = 4'd4;
  logic        req_signed = 1'b0;
  logic [31:0] req_address = '0;
  logic [31:0] req_data = '0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_fault;

  always #5 clock = ~clock;

  banked_memory #(
    .MEM_SIZE     (MEM_SIZE),
    .READ_LATENCY (LAT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_width   (req_width),
    .req_signed  (req_signed),
    .req_address (req_address),
    .req_data    (req_data),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_fault   (rsp_fault)
  );

  typedef struct {
    int          due;
    logic        fault;
    logic [31:0] data;
    string       tag;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_mem [MEM_SIZE];
  int         cyc        = 0;
  int         clear_left = CLEAR_CYCLES;
  bit         exp_ready  = 1'b0;
  int         n_checks   = 0;
  int         n_errors   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Reference: byte-addressed little-endian memory with the access rules.
  function automatic void model_access(input bit wr, input logic [3:0] w, input bit sgn,
                                       input logic [31:0] a, input logic [31:0] d,
                                       output bit f, output logic [31:0] r);
    int n;
    n = int'(w);
    r = '0;
    f = 1'b0;
    if (!(n == 1 || n == 2 || n == 4)) f = 1'b1;
    else if ((a % n) != 0)            f = 1'b1;
    else if (a >= MEM_SIZE)           f = 1'b1;
    if (f) return;
    for (int i = 0; i < n; i++) begin
      if (wr) model_mem[a + i] = d[8*i +: 8];
      else    r[8*i +: 8]      = model_mem[a + i];
    end
    if (!wr && sgn && n < 4 && r[8*n - 1]) r = r | (32'hFFFF_FFFF << (8*n));
  endfunction

  task automatic observe();
    bit   due_now;
    exp_t e;
    due_now = (exp_q.size() != 0) && (exp_q[0].due <= cyc);
    check("rsp_valid", 32'(rsp_valid), 32'(due_now));
    if (rsp_valid && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({e.tag, "_cycle"}, 32'(cyc), 32'(e.due));
      check({e.tag, "_fault"}, 32'(rsp_fault), 32'(e.fault));
      check({e.tag, "_data"}, rsp_data, e.data);
      $display("rsp %-8s cycle=%0d data=0x%08h fault=%0b", e.tag, cyc, rsp_data, rsp_fault);
    end else if (due_now) begin
      void'(exp_q.pop_front());
    end
    check("req_ready", 32'(req_ready), 32'(exp_ready));
  endtask

  // One cycle: check outputs, drive inputs, cross the rising edge, update model.
  task automatic drive(input bit v, input bit wr, input logic [3:0] w, input bit sgn,
                       input logic [31:0] a, input logic [31:0] d, input bit has_exp,
                       input logic [31:0] xd, input bit xf, input string tag,
                       output bit accepted);
    bit          mf;
    logic [31:0] md;
    exp_t        e;
    observe();
    req_valid   = v;
    req_write   = wr;
    req_width   = w;
    req_signed  = sgn;
    req_address = a;
    req_data    = d;
    accepted    = v && exp_ready && !reset;
    if (accepted) begin
      model_access(wr, w, sgn, a, d, mf, md);
      e.due   = cyc + LAT;
      e.fault = has_exp ? xf : mf;
      e.data  = has_exp ? xd : md;
      e.tag   = tag;
      exp_q.push_back(e);
    end
    @(negedge clock);
    cyc++;
    if (reset) begin
      exp_q.delete();
      clear_left = CLEAR_CYCLES;
      exp_ready  = 1'b0;
      foreach (model_mem[i]) model_mem[i] = 8'h00;
    end else if (clear_left > 0) begin
      clear_left--;
      exp_ready = (clear_left == 0);
    end
  endtask

  task automatic idle();
    bit acc;
    drive(1'b0, 1'b0, 4'd4, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, "idle", acc);
  endtask

  task automatic op(input bit wr, input logic [3:0] w, input bit sgn,
                    input logic [31:0] a, input logic [31:0] d, input string tag);
    bit acc;
    drive(1'b1, wr, w, sgn, a, d, 1'b0, 32'h0, 1'b0, tag, acc);
  endtask

  task automatic op_x(input bit wr, input logic [3:0] w, input bit sgn,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] xd, input bit xf, input string tag);
    bit acc;
    drive(1'b1, wr, w, sgn, a, d, 1'b1, xd, xf, tag, acc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit          acc;
    bit          v, wr, sgn;
    int          r, m;
    logic [3:0]  w;
    logic [31:0] a;

    foreach (model_mem[i]) model_mem[i] = 8'h00;
    @(negedge clock);
    idle();
    idle();
    reset = 1'b0;

    // Request held during CLEAR; accepted once the clear completes.
    acc = 1'b0;
    for (int i = 0; i < CLEAR_CYCLES + 8; i++) begin
      drive(1'b1, 1'b0, 4'd4, 1'b0, 32'h3FC, 32'h0, 1'b1, 32'h0, 1'b0, "lw_3fc", acc);
      if (acc) break;
    end

    // Sub-word loads with sign/zero extension.
    op_x(1'b1, 4'd4, 1'b0, 32'h10, 32'h80FF7F01, 32'h0,        1'b0, "sw_10");
    op_x(1'b0, 4'd1, 1'b1, 32'h11, 32'h0,        32'h0000007F, 1'b0, "lb_11");
    op_x(1'b0, 4'd1, 1'b1, 32'h12, 32'h0,        32'hFFFFFFFF, 1'b0, "lb_12");
    op_x(1'b0, 4'd1, 1'b0, 32'h13, 32'h0,        32'h00000080, 1'b0, "lbu_13");
    op_x(1'b0, 4'd2, 1'b1, 32'h12, 32'h0,        32'hFFFF80FF, 1'b0, "lh_12");
    // Upper halfword store lands in lanes 2/3.
    op_x(1'b1, 4'd4, 1'b0, 32'h20, 32'h0,        32'h0,        1'b0, "sw_20");
    op_x(1'b1, 4'd2, 1'b0, 32'h22, 32'h0000BEEF, 32'h0,        1'b0, "sh_22");
    op_x(1'b0, 4'd4, 1'b0, 32'h20, 32'h0,        32'hBEEF0000, 1'b0, "lw_20");
    // Faults suppress writes and return zero.
    op_x(1'b1, 4'd4, 1'b0, 32'h0,   32'hA5A5A5A5, 32'h0, 1'b0, "sw_0");
    op_x(1'b0, 4'd2, 1'b1, 32'h11,  32'h0,        32'h0, 1'b1, "lh_11");
    op_x(1'b0, 4'd4, 1'b0, 32'h12,  32'h0,        32'h0, 1'b1, "lw_12");
    op_x(1'b1, 4'd3, 1'b0, 32'h0,   32'hDEADBEEF, 32'h0, 1'b1, "w3_0");
    op_x(1'b1, 4'd2, 1'b0, 32'h1,   32'h00001234, 32'h0, 1'b1, "sh_1");
    op_x(1'b1, 4'd4, 1'b0, 32'h400, 32'h12345678, 32'h0, 1'b1, "sw_400");
    op_x(1'b0, 4'd4, 1'b0, 32'h0,   32'h0,        32'hA5A5A5A5, 1'b0, "lw_0");
    // Back-to-back loads: one response per cycle, in order.
    op_x(1'b1, 4'd4, 1'b0, 32'h4, 32'h44444444, 32'h0, 1'b0, "sw_4");
    op_x(1'b1, 4'd4, 1'b0, 32'h8, 32'h88888888, 32'h0, 1'b0, "sw_8");
    op_x(1'b0, 4'd4, 1'b0, 32'h0, 32'h0, 32'hA5A5A5A5, 1'b0, "b2b_0");
    op_x(1'b0, 4'd4, 1'b0, 32'h4, 32'h0, 32'h44444444, 1'b0, "b2b_4");
    op_x(1'b0, 4'd4, 1'b0, 32'h8, 32'h0, 32'h88888888, 1'b0, "b2b_8");
    for (int i = 0; i < LAT + 1; i++) idle();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 1500; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      wr  = ($urandom_range(0, 9) < 4);
      sgn = 1'($urandom_range(0, 1));
      r   = int'($urandom_range(0, 15));
      if (r < 5)       w = 4'd1;
      else if (r < 10) w = 4'd2;
      else if (r < 14) w = 4'd4;
      else if (r == 14) w = 4'd3;
      else             w = 4'd8;
      m = int'($urandom_range(0, 19));
      if (m < 15)      a = 32'($urandom_range(0, 63));
      else if (m < 18) a = 32'($urandom_range(0, MEM_SIZE - 1));
      else if (m == 18) a = 32'(MEM_SIZE) + 32'($urandom_range(0, 63));
      else             a = $urandom;
      if ($urandom_range(0, 3) != 0 && (w == 4'd2 || w == 4'd4)) a = a & ~(32'(w) - 32'd1);
      if (v) op(wr, w, sgn, a, $urandom, "rnd");
      else   idle();
    end
    for (int i = 0; i < LAT + 1; i++) idle();

    // Reset with two loads in flight: their responses must never appear.
    op(1'b0, 4'd4, 1'b0, 32'h10, 32'h0, "lw_pre0");
    op(1'b0, 4'd4, 1'b0, 32'h20, 32'h0, "lw_pre1");
    reset = 1'b1;
    idle();
    reset = 1'b0;
    acc = 1'b0;
    for (int i = 0; i < CLEAR_CYCLES + 8; i++) begin
      drive(1'b1, 1'b0, 4'd4, 1'b0, 32'h10, 32'h0, 1'b1, 32'h0, 1'b0, "lw_10_clr", acc);
      if (acc) break;
    end
    op_x(1'b0, 4'd4, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, "lw_20_clr");
    op_x(1'b0, 4'd4, 1'b0, 32'h4,  32'h0, 32'h0, 1'b0, "lw_4_clr");
    for (int i = 0; i < LAT + 2; i++) idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
